bcd_serial_subtractor: RTL and testbench

Multi-digit BCD subtractor that computes A − B over DIGITS packed BCD digits, one digit per clock, least-significant digit first, with a start/done handshake. It is the sequential stage that consumes operand pairs from the lab's input registers and drives the digit-wise subtract. It returns a sign-magnitude BCD result to the display and accumulator stages downstream.

---
 rtl/bcd_serial_subtractor.sv | 158 +++++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_subtractor.sv
// Serial packed-BCD subtractor: A - B one digit per clock, LSD first, with a
// sign-magnitude result. Negative results are recovered by a second
// complementing pass over the working register.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  neg,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SUB, COMP, DONE} state_t;

  // Handshake: start is sampled only while busy=0 (IDLE or DONE); done is a
  // single-cycle pulse in DONE, and diff/neg/err are valid from that cycle
  // until the next DONE entry.
  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            borrow_q, borrow_d, chk_q, chk_d;
  logic            neg_q, neg_d, err_q, err_d;

  logic [IW+1:0]   sh;
  logic [3:0]      x_dig, y_dig, d_dig;
  logic [4:0]      t;
  logic            b_out, last;
  logic [W-1:0]    res_wr;

  function automatic logic has_bad(input logic [W-1:0] v);
    has_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) has_bad = 1'b1;
    end
  endfunction

  // One shared digit slice: SUB uses a_i - b_i, COMP uses 0 - d_i.
  always_comb begin
    sh     = {idx_q, 2'b00};
    x_dig  = (state_q == COMP) ? 4'd0 : 4'(a_q >> sh);
    y_dig  = (state_q == COMP) ? 4'(res_q >> sh) : 4'(b_q >> sh);
    t      = {1'b0, x_dig} - {1'b0, y_dig} - {4'd0, borrow_q};
    b_out  = t[4];
    d_dig  = b_out ? (t[3:0] + 4'd10) : t[3:0];
    res_wr = (res_q & ~(W'(4'hF) << sh)) | (W'(d_dig) << sh);
    last   = (idx_q == IW'(DIGITS - 1));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    chk_d    = chk_q;
    diff_d   = diff_q;
    neg_d    = neg_q;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          res_d    = '0;
          idx_d    = '0;
          borrow_d = 1'b0;
          chk_d    = 1'b1;
          state_d  = SUB;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SUB: begin
        if (chk_q) begin
          // First SUB cycle validates the latched operands before any digit work.
          chk_d = 1'b0;
          if (has_bad(a_q) || has_bad(b_q)) begin
            state_d = DONE;
            diff_d  = '0;
            neg_d   = 1'b0;
            err_d   = 1'b1;
          end
        end else begin
          res_d    = res_wr;
          borrow_d = b_out;
          idx_d    = idx_q + IW'(1);
          if (last) begin
            if (b_out) begin
              idx_d    = '0;
              borrow_d = 1'b0;
              state_d  = COMP;
            end else begin
              state_d = DONE;
              diff_d  = res_wr;
              neg_d   = 1'b0;
              err_d   = 1'b0;
            end
          end
        end
      end
      COMP: begin
        res_d    = res_wr;
        borrow_d = b_out;
        idx_d    = idx_q + IW'(1);
        if (last) begin
          state_d = DONE;
          diff_d  = res_wr;
          neg_d   = 1'b1;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      chk_q    <= 1'b0;
      diff_q   <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      chk_q    <= chk_d;
      diff_q   <= diff_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign busy = (state_q == SUB) || (state_q == COMP);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign neg  = neg_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Bench for bcd_serial_subtractor: directed and random operand pairs checked
// against an integer-arithmetic model, plus handshake, latency and reset cases.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, neg, err;
  logic [W-1:0] diff;

  int n_vec = 0;
  int n_bad = 0;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    int m = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] ed, output logic en,
                       output logic ee, output int el);
    logic bad = 1'b0;
    int ia, ib;
    for (int i = 0; i < DIGITS; i++)
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1'b1;
    if (bad) begin
      ed = '0; en = 1'b0; ee = 1'b1; el = 1;
    end else begin
      ia = bcd2int(av);
      ib = bcd2int(bv);
      ee = 1'b0;
      en = (ia < ib);
      ed = int2bcd(en ? ib - ia : ia - ib);
      el = en ? 2 * DIGITS + 1 : DIGITS + 1;
    end
  endtask

  function automatic logic [W-1:0] rand_bcd();
    return int2bcd(int'($urandom_range(0, 9999)));
  endfunction

  // ---------------- drivers ----------------
  // Entered at a negedge; returns at the negedge after E0 with start dropped
  // and the operand buses scrambled so any re-sampling would be visible.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic await_result(input logic [W-1:0] av, input logic [W-1:0] bv,
                              input int k0, input string tag);
    logic [W-1:0] ed;
    logic en, ee;
    int el;
    int k = k0;
    model(av, bv, ed, en, ee, el);
    while (done !== 1'b1 && k < 40) begin
      n_vec++;
      if (busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s busy at k=%0d: got %b want 1", tag, k, busy);
      end
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k !== el) begin
      n_bad++;
      $display("FAIL %s latency a=%h b=%h: got %0d want %0d", tag, av, bv, k, el);
    end
    n_vec++;
    if (diff !== ed) begin
      n_bad++;
      $display("FAIL %s diff a=%h b=%h: got %h want %h", tag, av, bv, diff, ed);
    end
    n_vec++;
    if (neg !== en) begin
      n_bad++;
      $display("FAIL %s neg a=%h b=%h: got %b want %b", tag, av, bv, neg, en);
    end
    n_vec++;
    if (err !== ee) begin
      n_bad++;
      $display("FAIL %s err a=%h b=%h: got %b want %b", tag, av, bv, err, ee);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy in done: got %b want 0", tag, busy);
    end
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
    logic [W-1:0] ed;
    logic en, ee;
    int el;
    model(av, bv, ed, en, ee, el);
    @(negedge clk);
    launch(av, bv);
    await_result(av, bv, 0, tag);
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || diff !== ed || neg !== en || err !== ee) begin
      n_bad++;
      $display("FAIL %s after done: got done=%b diff=%h neg=%b err=%b want 0 %h %b %b",
               tag, done, diff, neg, err, ed, en, ee);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, diff, neg, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_hold: got busy=%b done=%b diff=%h neg=%b err=%b want all 0",
               busy, done, diff, neg, err);
    end
    rst_n = 1'b1;
    do_op(16'h0007, 16'h0004, "reset_pre");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, diff, neg, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got busy=%b done=%b diff=%h neg=%b err=%b want all 0",
               busy, done, diff, neg, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[9] = '{16'h0003, 16'h0007, 16'h1000, 16'h0042, 16'h0008,
                            16'h0000, 16'h0004, 16'h000A, 16'h0012};
    logic [W-1:0] tb_[9] = '{16'h0002, 16'h0004, 16'h0001, 16'h0042, 16'h0009,
                             16'h9999, 16'h0005, 16'h0008, 16'h00B0};
    for (int i = 0; i < 9; i++) do_op(ta[i], tb_[i], "directed");
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv;
    for (int i = 0; i < 40; i++) begin
      av = rand_bcd();
      bv = ($urandom_range(0, 3) == 0) ? av : rand_bcd();
      if ($urandom_range(0, 9) == 0) av[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      do_op(av, bv, "random");
    end
  endtask

  task automatic test_start_held();
    @(negedge clk);
    a = 16'h0305; b = 16'h0417; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h0001; b = 16'h0000;
    repeat (2) @(negedge clk);
    start = 1'b0;
    await_result(16'h0305, 16'h0417, 2, "start_held");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    a1 = rand_bcd(); b1 = rand_bcd();
    a2 = 16'h0100; b2 = 16'h0200;
    @(negedge clk);
    launch(a1, b1);
    await_result(a1, b1, 0, "b2b_first");
    launch(a2, b2);
    await_result(a2, b2, 0, "b2b_second");
  endtask

  task automatic test_abort();
    bit saw_done = 1'b0;
    do_op(16'h0050, 16'h0020, "abort_pre");
    @(negedge clk);
    launch(16'h0123, 16'h0456);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, diff, neg, err} !== '0) begin
      n_bad++;
      $display("FAIL abort_reset: got busy=%b done=%b diff=%h neg=%b err=%b want all 0",
               busy, done, diff, neg, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done) begin
      n_bad++;
      $display("FAIL abort_quiet: got activity after reset want none");
    end
    do_op(16'h0456, 16'h0123, "abort_post");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
